pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage in-order core (if/id, id, id/ex, ex, ex/mem, mem/wb).
- Keeps a register scoreboard of in-flight writes.
- Stalls the front end on RAW/WAW hazards, since the pipeline has no forwarding.
- Holds EX for multi-cycle ALU ops.
- Flushes if/id and id/ex on a taken branch resolved in EX.
- Replaces the ad-hoc block signal out of id/ex.

---
 rtl/pipeline_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the 5-stage in-order core.
// Tracks in-flight register writes in a scoreboard, stalls the front end on
// RAW/WAW hazards (no forwarding), holds EX for multi-cycle ALU ops, and
// flushes if/id and id/ex on a taken branch resolved in EX.
//
// Optional build macro: PIPE_CTRL_PERF_EN adds saturating stall/flush
// cycle counters (perf_stall_cnt, perf_flush_cnt).
//
// Control semantics: an ID instruction moves into id/ex exactly in the cycle
// where issue=1. Whenever stall_front=1 the PC and if/id keep their contents
// and the ID instruction is offered again next cycle. idex_bubble loads a NOP
// into id/ex, ex_hold freezes id/ex and the EX inputs, and the two flush
// outputs clear their pipeline registers at the next clock edge.
module pipeline_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int MULTI_LAT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic                  id_rs1_used,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_we,
    input  logic                  id_multi,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  ex_br_taken,
    output logic                  stall_front,
    output logic                  idex_bubble,
    output logic                  ex_hold,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic                  issue,
    output logic [NUM_REGS-1:0]   sb_pending
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);

    // Counter wide enough to hold MULTI_LAT-1 for any MULTI_LAT >= 1.
    localparam int CNT_W = $clog2(MULTI_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // With MULTI_LAT==1 multi-cycle ops finish in one EX cycle, so no hold.
    localparam bit MULTI_EN = (MULTI_LAT > 1);

    typedef enum logic {
        RUN     = 1'b0,
        EX_BUSY = 1'b1
    } state_t;

    // Registered state: FSM, hold down-counter, pending-write scoreboard.
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_REGS-1:0]   r_pend;

    // Next-state values and combinational controls.
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [NUM_REGS-1:0]   w_pend_nxt;
    logic                  w_hazard;
    logic                  w_rs1_hit;
    logic                  w_rs2_hit;
    logic                  w_rd_hit;
    logic                  w_stall_front;
    logic                  w_idex_bubble;
    logic                  w_ex_hold;
    logic                  w_flush_ifid;
    logic                  w_flush_idex;
    logic                  w_issue;
    logic [NUM_REGS-1:0]   w_sb_pending;

    // Hazard detection: any used operand or the destination still pending.
    // r0 never becomes pending, but the explicit !=0 terms keep that obvious.
    always_comb begin
        w_rs1_hit = id_rs1_used && (id_rs1 != '0) && r_pend[id_rs1];
        w_rs2_hit = id_rs2_used && (id_rs2 != '0) && r_pend[id_rs2];
        w_rd_hit  = id_rd_we    && (id_rd  != '0) && r_pend[id_rd];
        w_hazard  = id_valid && (w_rs1_hit || w_rs2_hit || w_rd_hit);
    end

    // FSM next-state and control outputs; everything forced low in reset.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_stall_front = 1'b0;
        w_idex_bubble = 1'b0;
        w_ex_hold     = 1'b0;
        w_flush_ifid  = 1'b0;
        w_flush_idex  = 1'b0;
        w_issue       = 1'b0;
        if (rst) begin
            case (r_state)
                RUN: begin
                    if (ex_br_taken) begin
                        // Taken branch wins over any hazard: the ID
                        // instruction is on the wrong path and is discarded.
                        w_flush_ifid = 1'b1;
                        w_flush_idex = 1'b1;
                    end else if (w_hazard) begin
                        w_stall_front = 1'b1;
                        w_idex_bubble = 1'b1;
                    end else begin
                        w_issue = id_valid;
                        if (id_valid && id_multi && MULTI_EN) begin
                            w_state_nxt = EX_BUSY;
                            w_cnt_nxt   = CNT_LOAD;
                        end
                    end
                end
                EX_BUSY: begin
                    // A branch cannot be resolved while EX is occupied by a
                    // multi-cycle op, so ex_br_taken is not looked at here.
                    w_ex_hold     = 1'b1;
                    w_stall_front = 1'b1;
                    w_cnt_nxt     = r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Scoreboard next value: writeback clears first, then issue sets, so a
    // set on the same index wins; r0 is never marked pending.
    always_comb begin
        w_pend_nxt = r_pend;
        if (wb_we && (wb_rd != '0)) begin
            w_pend_nxt[wb_rd] = 1'b0;
        end
        if (w_issue && id_rd_we && (id_rd != '0)) begin
            w_pend_nxt[id_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    // Scoreboard bits are visible to the core only outside reset.
    always_comb begin
        w_sb_pending = rst ? r_pend : '0;
    end

    // State register: FSM, counter and scoreboard, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    assign stall_front = w_stall_front;
    assign idex_bubble = w_idex_bubble;
    assign ex_hold     = w_ex_hold;
    assign flush_ifid  = w_flush_ifid;
    assign flush_idex  = w_flush_idex;
    assign issue       = w_issue;
    assign sb_pending  = w_sb_pending;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;

    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_stall_front && (r_perf_stall_cnt != '1)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if (w_flush_ifid && (r_perf_flush_cnt != '1)) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
    assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl (default parameters: 5-bit indices, 32 regs,
// MULTI_LAT=4). Each driven cycle pushes its expected controls and scoreboard
// into a queue; a negedge monitor pops and compares against the DUT.
module tb_pipeline_ctrl;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // DUT
    // ------------------------------------------------------------------
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic        id_rs1_used;
    logic [4:0]  id_rs2;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic        id_multi;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic        ex_br_taken;
    logic        stall_front;
    logic        idex_bubble;
    logic        ex_hold;
    logic        flush_ifid;
    logic        flush_idex;
    logic        issue;
    logic [31:0] sb_pending;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    pipeline_ctrl #(
        .REG_ADDR_W (5),
        .NUM_REGS   (32),
        .MULTI_LAT  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs1_used (id_rs1_used),
        .id_rs2      (id_rs2),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_rd_we    (id_rd_we),
        .id_multi    (id_multi),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .ex_br_taken (ex_br_taken),
        .stall_front (stall_front),
        .idex_bubble (idex_bubble),
        .ex_hold     (ex_hold),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex),
        .issue       (issue),
        .sb_pending  (sb_pending)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    // Control vector order: {stall_front, idex_bubble, ex_hold, flush_ifid, flush_idex, issue}
    localparam logic [5:0] C_Z = 6'b000000;  // idle
    localparam logic [5:0] C_I = 6'b000001;  // issue
    localparam logic [5:0] C_S = 6'b110000;  // hazard stall + bubble
    localparam logic [5:0] C_H = 6'b101000;  // EX hold + front stall
    localparam logic [5:0] C_F = 6'b000110;  // branch flush

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [37:0] exp_q[$];
    string       tag_q[$];
    int          n_cmp;
    int          n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare the oldest expectation mid-cycle, away from the edge.
    always @(negedge clk) begin
        logic [37:0] e;
        string       t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, "/ctl"},
                  {58'd0, stall_front, idex_bubble, ex_hold, flush_ifid, flush_idex, issue},
                  {58'd0, e[37:32]});
            check({t, "/pend"}, {32'd0, sb_pending}, {32'd0, e[31:0]});
        end
    end

    // ------------------------------------------------------------------
    // Driver: apply one cycle of inputs and queue its expected outputs.
    // ------------------------------------------------------------------
    task automatic drive(input string tag, input logic rstn,
                         input logic v, input logic [4:0] rs1, input logic rs1u,
                         input logic [4:0] rs2, input logic rs2u,
                         input logic [4:0] rd, input logic rdwe, input logic multi,
                         input logic wbwe, input logic [4:0] wbrd, input logic br,
                         input logic [5:0] ectl, input logic [31:0] epend);
        rst         = rstn;
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = rs1u;
        id_rs2      = rs2;
        id_rs2_used = rs2u;
        id_rd       = rd;
        id_rd_we    = rdwe;
        id_multi    = multi;
        wb_we       = wbwe;
        wb_rd       = wbrd;
        ex_br_taken = br;
        exp_q.push_back({ectl, epend});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the stimulus is fixed-length, so this only trips on a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
        id_rd = 0; id_rd_we = 0; id_multi = 0; wb_we = 0; wb_rd = 0; ex_br_taken = 0;
        @(posedge clk);
        #1;

        //     tag        rst v  rs1 u  rs2 u  rd  we mul wbwe wbrd br  ctl  pend
        // Reset: outputs forced low regardless of ID inputs.
        drive("rst0",     0,  1, 0,  0, 0,  0, 5,  1, 0,  0,   0,   0,  C_Z, 32'h0);
        drive("rst1",     0,  1, 5,  1, 0,  0, 0,  0, 0,  0,   0,   0,  C_Z, 32'h0);

        // RAW on r5: WB three cycles after issue, stall includes the WB cycle.
        drive("raw_iss",  1,  1, 0,  0, 0,  0, 5,  1, 0,  0,   0,   0,  C_I, 32'h0);
        drive("raw_st1",  1,  1, 5,  1, 0,  0, 6,  1, 0,  0,   0,   0,  C_S, 32'h20);
        drive("raw_st2",  1,  1, 5,  1, 0,  0, 6,  1, 0,  0,   0,   0,  C_S, 32'h20);
        drive("raw_st3",  1,  1, 5,  1, 0,  0, 6,  1, 0,  1,   5,   0,  C_S, 32'h20);
        drive("raw_go",   1,  1, 5,  1, 0,  0, 6,  1, 0,  0,   0,   0,  C_I, 32'h0);
        drive("raw_wb6",  1,  0, 0,  0, 0,  0, 0,  0, 0,  1,   6,   0,  C_Z, 32'h40);

        // Branch overrides a hazard on pending r7; r9 must not be marked.
        drive("br_iss",   1,  1, 0,  0, 0,  0, 7,  1, 0,  0,   0,   0,  C_I, 32'h0);
        drive("br_flush", 1,  1, 7,  1, 0,  0, 9,  1, 0,  0,   0,   1,  C_F, 32'h80);
        drive("br_after", 1,  0, 0,  0, 0,  0, 0,  0, 0,  0,   0,   0,  C_Z, 32'h80);
        drive("br_wb7",   1,  0, 0,  0, 0,  0, 0,  0, 0,  1,   7,   0,  C_Z, 32'h80);
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall", {32'd0, perf_stall_cnt}, 64'd3);
        check("perf_flush", {32'd0, perf_flush_cnt}, 64'd1);
`endif
        drive("br_idle",  1,  0, 0,  0, 0,  0, 0,  0, 0,  0,   0,   0,  C_Z, 32'h0);

        // r0 writes never become pending, back-to-back issue.
        drive("r0_wr",    1,  1, 0,  0, 0,  0, 0,  1, 0,  0,   0,   0,  C_I, 32'h0);
        drive("r0_rd",    1,  1, 0,  1, 0,  1, 0,  1, 0,  0,   0,   0,  C_I, 32'h0);
        drive("r0_idle",  1,  0, 0,  0, 0,  0, 0,  0, 0,  0,   0,   0,  C_Z, 32'h0);

        // Multi-cycle op: three held cycles; WB clears and branch ignored while busy.
        drive("mc_iss",   1,  1, 0,  0, 0,  0, 3,  1, 1,  0,   0,   0,  C_I, 32'h0);
        drive("mc_h1",    1,  1, 3,  1, 0,  0, 0,  0, 0,  1,   3,   0,  C_H, 32'h08);
        drive("mc_h2",    1,  1, 3,  1, 0,  0, 0,  0, 0,  0,   0,   1,  C_H, 32'h0);
        drive("mc_h3",    1,  1, 3,  1, 0,  0, 0,  0, 0,  0,   0,   0,  C_H, 32'h0);
        drive("mc_run",   1,  1, 3,  1, 0,  0, 0,  0, 0,  0,   0,   0,  C_I, 32'h0);
        drive("mc_idle",  1,  0, 0,  0, 0,  0, 0,  0, 0,  0,   0,   0,  C_Z, 32'h0);

        // WAW on r7: stalls through its WB cycle, then issues and re-marks r7.
        drive("waw_iss",  1,  1, 0,  0, 0,  0, 7,  1, 0,  0,   0,   0,  C_I, 32'h0);
        drive("waw_st",   1,  1, 0,  0, 0,  0, 7,  1, 0,  1,   7,   0,  C_S, 32'h80);
        drive("waw_go",   1,  1, 0,  0, 0,  0, 7,  1, 0,  0,   0,   0,  C_I, 32'h0);
        drive("waw_wb",   1,  0, 0,  0, 0,  0, 0,  0, 0,  1,   7,   0,  C_Z, 32'h80);
        drive("waw_idle", 1,  0, 0,  0, 0,  0, 0,  0, 0,  0,   0,   0,  C_Z, 32'h0);

        // Reset during EX_BUSY with r5 and r7 pending.
        drive("mr_i5",    1,  1, 0,  0, 0,  0, 5,  1, 0,  0,   0,   0,  C_I, 32'h0);
        drive("mr_i7",    1,  1, 0,  0, 0,  0, 7,  1, 1,  0,   0,   0,  C_I, 32'h20);
        drive("mr_rst",   0,  1, 5,  1, 0,  0, 0,  0, 0,  0,   0,   0,  C_Z, 32'h0);
        drive("mr_run",   1,  1, 5,  1, 0,  0, 0,  0, 0,  0,   0,   0,  C_I, 32'h0);
        drive("mr_idle",  1,  0, 0,  0, 0,  0, 0,  0, 0,  0,   0,   0,  C_Z, 32'h0);

        // rs2-only hazard; unused source fields must be ignored.
        drive("rs2_iss",  1,  1, 0,  0, 0,  0, 4,  1, 0,  0,   0,   0,  C_I, 32'h0);
        drive("rs2_st",   1,  1, 4,  0, 4,  1, 0,  0, 0,  0,   0,   0,  C_S, 32'h10);
        drive("unused",   1,  1, 4,  0, 4,  0, 8,  0, 0,  0,   0,   0,  C_I, 32'h10);
        drive("rs2_wb",   1,  0, 0,  0, 0,  0, 0,  0, 0,  1,   4,   0,  C_Z, 32'h10);
        drive("end_idle", 1,  0, 0,  0, 0,  0, 0,  0, 0,  0,   0,   0,  C_Z, 32'h0);

        // Let the monitor drain the last expectation.
        @(negedge clk);
        #1;
        check("q_drained", 64'(exp_q.size()), 64'd0);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
